sr_pulse_ctrl: RTL and testbench

SR_PULSE_CTRL -- requirements
Module: sr_pulse_ctrl

---
 rtl/sr_pulse_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sr_pulse_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_ctrl.sv
// Debounced set/clear push-button front end driving an external SR flip-flop.
// Issues single-cycle s/r pulses, then checks the flop's readback.
module sr_pulse_deb #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic       lvl;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      cnt  <= 8'd0;
      rise <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 != lvl) begin
        if (cnt == LAST) begin
          lvl  <= s2;
          cnt  <= 8'd0;
          rise <= s2;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

module sr_pulse_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       clr_btn,
  input  logic       q_fb,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic       err,
  output logic [7:0] set_count,
  output logic [7:0] clr_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0] state;
  logic       req_set;
  logic       req_clr;
  logic       pend_set;
  logic       pend_clr;
  logic       want_set;
  logic       want_clr;
  logic       exp_q;

  sr_pulse_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk  (clk),
    .rst  (rst),
    .raw  (set_btn),
    .rise (req_set)
  );

  sr_pulse_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk  (clk),
    .rst  (rst),
    .raw  (clr_btn),
    .rise (req_clr)
  );

  assign want_set = req_set | pend_set;
  assign want_clr = req_clr | pend_clr;
  assign busy     = (state != IDLE);

  // Pending bits hold requests that arrive while a pulse is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
    end else if (state == IDLE) begin
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
    end else begin
      pend_set <= pend_set | req_set;
      pend_clr <= pend_clr | req_clr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s         <= 1'b0;
      r         <= 1'b0;
      exp_q     <= 1'b0;
      conflict  <= 1'b0;
      err       <= 1'b0;
      set_count <= 8'd0;
      clr_count <= 8'd0;
    end else begin
      s <= 1'b0;
      r <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            (want_set && want_clr): begin
              conflict <= 1'b1;
            end
            (want_set && !want_clr): begin
              state     <= PULSE;
              s         <= 1'b1;
              exp_q     <= 1'b1;
              set_count <= set_count + 8'd1;
            end
            (!want_set && want_clr): begin
              state     <= PULSE;
              r         <= 1'b1;
              exp_q     <= 1'b0;
              clr_count <= clr_count + 8'd1;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        PULSE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb != exp_q) begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Scoreboard bench for sr_pulse_ctrl: expected pulses queued by stimulus,
// popped and checked by an independent monitor.
module tb_sr_pulse_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_btn;
  logic       clr_btn;
  logic       q_fb;
  logic       s;
  logic       r;
  logic       busy;
  logic       conflict;
  logic       err;
  logic [7:0] set_count;
  logic [7:0] clr_count;

  typedef struct {
    bit         is_set;
    logic [7:0] sc;
    logic [7:0] cc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sr_pulse_ctrl #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_btn   (set_btn),
    .clr_btn   (clr_btn),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .conflict  (conflict),
    .err       (err),
    .set_count (set_count),
    .clr_count (clr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string name, longint got, longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(bit is_set, logic [7:0] sc, logic [7:0] cc, int c);
    exp_t e;
    e.is_set = is_set;
    e.sc     = sc;
    e.cc     = cc;
    e.cyc    = c;
    q.push_back(e);
  endtask

  // Monitor: every pulse seen on s/r must match the head of the queue
  always @(negedge clk) begin
    if (rst === 1'b1 && (s || r)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: s=%b r=%b sc=%0d cc=%0d cyc=%0d",
                 s, r, set_count, clr_count, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (s !== e.is_set || r !== !e.is_set || busy !== 1'b1 ||
            set_count !== e.sc || clr_count !== e.cc ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          bad++;
          $display("FAIL pulse: got s=%b r=%b busy=%b sc=%0d cc=%0d cyc=%0d want s=%b r=%b busy=1 sc=%0d cc=%0d cyc=%0d",
                   s, r, busy, set_count, clr_count, cyc,
                   e.is_set, !e.is_set, e.sc, e.cc, e.cyc);
        end
      end
    end
  end

  function automatic logic [20:0] outs();
    return {s, r, busy, conflict, err, set_count, clr_count};
  endfunction

  initial begin
    int  e0;
    bit  seen;
    rst     = 1'b0;
    set_btn = 1'b0;
    clr_btn = 1'b0;
    q_fb    = 1'b0;
    tick(3);
    chk("reset_state", outs(), 0);
    rst = 1'b1;
    tick(2);

    // held set press: s after edge 6, readback good
    q_fb = 1'b1;
    e0 = cyc + 1;
    push(1'b1, 8'd1, 8'd0, e0 + 6);
    set_btn = 1'b1;
    tick(12);
    set_btn = 1'b0;
    tick(10);
    chk("err_after_set", err, 0);
    chk("busy_idle", busy, 0);

    // 3-cycle glitch: no pulse
    set_btn = 1'b1;
    tick(3);
    set_btn = 1'b0;
    tick(12);
    chk("glitch_counts", {set_count, clr_count}, {8'd1, 8'd0});

    // full press after glitch still needs the full debounce
    e0 = cyc + 1;
    push(1'b1, 8'd2, 8'd0, e0 + 6);
    set_btn = 1'b1;
    tick(10);
    set_btn = 1'b0;
    tick(10);

    // simultaneous presses: conflict, no pulse
    set_btn = 1'b1;
    clr_btn = 1'b1;
    tick(14);
    chk("conflict_set", conflict, 1);
    chk("conflict_counts", {set_count, clr_count}, {8'd2, 8'd0});
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tick(10);

    // clear with q_fb stuck at 1: err sticky
    e0 = cyc + 1;
    push(1'b0, 8'd2, 8'd1, e0 + 6);
    clr_btn = 1'b1;
    tick(10);
    chk("err_after_clr", err, 1);
    clr_btn = 1'b0;
    tick(10);
    chk("err_sticky", err, 1);
    chk("conflict_sticky", conflict, 1);

    // clear debounced during set pulse: served from pending
    e0 = cyc + 1;
    push(1'b1, 8'd3, 8'd1, e0 + 6);
    push(1'b0, 8'd3, 8'd2, e0 + 9);
    set_btn = 1'b1;
    tick(1);
    clr_btn = 1'b1;
    tick(12);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tick(12);
    chk("pend_counts", {set_count, clr_count}, {8'd3, 8'd2});

    // drive set_count through the 255->0 wrap
    for (int i = 0; i < 253; i++) begin
      push(1'b1, 8'(4 + i), 8'd2, -1);
      set_btn = 1'b1;
      tick(9);
      set_btn = 1'b0;
      tick(8);
    end
    chk("wrap_count", set_count, 0);
    chk("wrap_no_flag", {conflict, err}, 2'b11);

    // reset asserted in the middle of a pulse
    e0 = cyc + 1;
    push(1'b1, 8'd1, 8'd2, e0 + 6);
    set_btn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (s) seen = 1'b1;
    end
    chk("pulse_before_rst", seen, 1);
    #2 rst = 1'b0;
    #1 chk("rst_mid_pulse", outs(), 0);
    tick(2);
    chk("rst_held", outs(), 0);

    // button held across reset release: exactly one pulse
    e0 = cyc + 1;
    push(1'b1, 8'd1, 8'd0, e0 + 6);
    rst = 1'b1;
    tick(14);
    set_btn = 1'b0;
    tick(10);
    chk("post_rst_counts", {set_count, clr_count}, {8'd1, 8'd0});
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
